pipe_hazard_ctrl: RTL

Pipeline hazard controller for the 4-stage MCU pipeline (IF, DOF, EX, WB) with an 8-entry register file. It tracks the destination register and write enable of the instructions in EX and WB, and detects read-after-write hazards for the instruction in DOF. On a hazard it stalls IF/DOF and injects bubbles into EX. It also flushes on taken branches and keeps saturating performance counters. The block sits between the instruction decoder and the pipeline registers and drives the PC and IR enables.

---
 rtl/pipe_hazard_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard stall, branch flush and performance counters for the 4-stage MCU pipeline.
// Hazard detection is zero-latency (combinational); `hold` freezes all state.
module pipe_hazard_ctrl #(
  parameter int AW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          dof_valid,
  input  logic [AW-1:0] dof_aa,
  input  logic [AW-1:0] dof_ba,
  input  logic          dof_ma,
  input  logic          dof_mb,
  input  logic [AW-1:0] dof_da,
  input  logic          dof_rw,
  input  logic          ex_branch,
  output logic          pc_en,
  output logic          ir_en,
  output logic          ir_clr,
  output logic          bubble,
  output logic          dhs,
  output logic [AW-1:0] ex_da,
  output logic [AW-1:0] wb_da,
  output logic          ex_rw,
  output logic          wb_rw,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt,
  output logic          err
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STALL1 = 2'd1;
  localparam logic [1:0] ST_STALL2 = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [1:0] st;
  logic       hz_ex;
  logic       hz_wb;
  logic       stall;
  logic       flush;

  // R0 is hard-wired, so a write to it can never be a hazard source.
  assign hz_ex = ex_rw && (ex_da != '0) &&
                 ((!dof_ma && (dof_aa == ex_da)) || (!dof_mb && (dof_ba == ex_da)));
  assign hz_wb = wb_rw && (wb_da != '0) &&
                 ((!dof_ma && (dof_aa == wb_da)) || (!dof_mb && (dof_ba == wb_da)));

  // A taken branch kills the DOF instruction, so it overrides any stall.
  assign flush  = ex_branch && !hold;
  assign stall  = dof_valid && (hz_ex || hz_wb) && !flush && !hold;
  assign dhs    = !stall;
  assign pc_en  = !hold && !stall;
  assign ir_en  = !hold && !stall;
  assign ir_clr = flush;
  assign bubble = !hold && (stall || flush || !dof_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_da     <= '0;
      ex_rw     <= 1'b0;
      wb_da     <= '0;
      wb_rw     <= 1'b0;
      st        <= ST_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
      err       <= 1'b0;
    end else if (!hold) begin
      wb_da <= ex_da;
      wb_rw <= ex_rw;
      if (bubble) begin
        ex_da <= '0;
        ex_rw <= 1'b0;
      end else begin
        ex_da <= dof_da;
        ex_rw <= dof_rw;
      end

      if (stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;

      // A single producer can stall at most twice; a third stall means a broken pipeline.
      case (st)
        ST_RUN:    if (stall) st <= ST_STALL1;
        ST_STALL1: st <= stall ? ST_STALL2 : ST_RUN;
        ST_STALL2: begin
          if (stall) begin
            st  <= ST_ERR;
            err <= 1'b1;
          end else begin
            st <= ST_RUN;
          end
        end
        ST_ERR:    if (!stall) st <= ST_RUN;
        default:   st <= ST_RUN;
      endcase
    end
  end

endmodule
